mc_serial_rx: RTL

Single-wire redstone serial receiver. Samples an idle-low line driven by a remote serial transmitter, frames it as start bit, WIDTH data bits (LSB first), stop bit, and presents each received word on a held VALID/ACK interface to local logic. It sits at the receiving end of every inter-module redstone link and maps onto MC_DFF31/MC_ADFF31 cells plus gates.

---
 rtl/mc_serial_rx_if.sv | 23 ++
 rtl/mc_serial_rx.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mc_serial_rx_if.sv
// Receiver-side bus: serial line in, held VALID/ACK word interface out.
interface mc_serial_rx_if #(
  parameter int WIDTH = 8
);
  logic             rxd;
  logic             ack;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             overrun;
  logic             frame_err;

  // Remote/consumer side: drives the line and the acknowledge.
  modport master (
    output rxd, ack,
    input  data, valid, overrun, frame_err
  );

  // Receiver side.
  modport slave (
    input  rxd, ack,
    output data, valid, overrun, frame_err
  );
endinterface

// File: rtl/mc_serial_rx.sv
// Single-wire serial receiver: idle-low line, start bit 1, WIDTH data bits
// LSB first, stop bit 0. Each good word is held on VALID until ACKed.
module mc_serial_rx #(
  parameter int WIDTH         = 8,
  parameter int TICKS_PER_BIT = 4
) (
  input  logic           clk_i,
  input  logic           arst_n_i,
  mc_serial_rx_if.slave  rx_if
);
  localparam int H      = TICKS_PER_BIT / 2;
  localparam int TICK_W = $clog2(TICKS_PER_BIT);
  localparam int BIT_W  = $clog2(WIDTH + 1);

  // Tick counter reads (cycles since phase start - 1), so a sample at
  // phase cycle k happens when the counter equals k-1.
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(H - 1);
  localparam logic [TICK_W-1:0] CELL_LAST = TICK_W'(TICKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
  } state_t;

  state_t             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;
  logic               frame_err_q, frame_err_d;
  logic               frame_good;

  // Framing FSM plus word delivery / handshake bookkeeping.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    frame_good  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_if.rxd) begin
          state_d = S_START;
          tick_d  = '0;
        end
      end
      S_START: begin
        if (tick_q == HALF_LAST) begin
          tick_d  = '0;
          bit_d   = '0;
          // A start bit that has vanished by mid-cell is a glitch.
          state_d = rx_if.rxd ? S_DATA : S_IDLE;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_DATA: begin
        if (tick_q == CELL_LAST) begin
          tick_d  = '0;
          // LSB arrives first, so shift in from the top.
          shift_d = WIDTH'({rx_if.rxd, shift_q} >> 1);
          if (bit_q == BIT_LAST) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_STOP: begin
        if (tick_q == CELL_LAST) begin
          tick_d = '0;
          if (rx_if.rxd) begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end else begin
            frame_good = 1'b1;
            state_d    = S_IDLE;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_BREAK: begin
        // Line must fall before a new start can be recognised.
        if (!rx_if.rxd) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_good) begin
      if (!valid_q || rx_if.ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        if (valid_q) overrun_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && rx_if.ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_if.data      = data_q;
  assign rx_if.valid     = valid_q;
  assign rx_if.overrun   = overrun_q;
  assign rx_if.frame_err = frame_err_q;
endmodule
